// File: rtl/fir_pkg.sv
// Shared helpers for the streaming FIR filter: sizing, reset coefficients,
// and the final round/shift/saturate step.
package fir_pkg;

  // Ceiling log2 for sizing address and accumulator fields (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Accumulator width: a full product plus enough headroom to add TAPS of
  // them without overflow.
  function automatic int acc_width(input int width, input int cw, input int taps);
    return width + cw + clog2(taps) + 1;
  endfunction

  // Reset coefficient for tap k: unity gain through tap 0 once the sum is
  // shifted down, zero elsewhere.
  function automatic logic [63:0] reset_coef(input int k, input int shift);
    return (k == 0) ? (64'd1 << shift) : 64'd0;
  endfunction

  // Add the half-up rounding bias (if enabled), shift down, clamp to the
  // largest unsigned value representable in width bits.
  function automatic logic [63:0] round_sat(input logic [63:0] sum, input int width,
                                            input int shift, input bit round);
    logic [63:0] bias;
    logic [63:0] val;
    logic [63:0] vmax;
    bias = (round && shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
    val  = (sum + bias) >> shift;
    vmax = (64'd1 << width) - 64'd1;
    return (val > vmax) ? vmax : val;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample history for the FIR filter. Shifts only on accepted samples; clear
// empties the history, but a sample accepted in the same cycle still lands
// as the newest history word.
module fir_delay_line #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_valid,
  input  logic                        i_clear,
  input  logic [WIDTH-1:0]            i_data,
  output logic [(TAPS-1)*WIDTH-1:0]   o_hist
);

  localparam int HW = (TAPS - 1) * WIDTH;

  logic [HW-1:0] r_hist;

  assign o_hist = r_hist;

  // Word 0 holds x[n-1]; shifting by WIDTH pushes older samples up and drops the oldest.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hist <= '0;
    end else if (i_valid) begin
      if (i_clear) r_hist <= HW'(i_data);
      else         r_hist <= (r_hist << WIDTH) | HW'(i_data);
    end else if (i_clear) begin
      r_hist <= '0;
    end
  end

endmodule

// File: rtl/fir_filter.sv
// Streaming FIR filter with runtime-writable coefficients. Stage 1 registers
// the per-tap products, stage 2 registers the rounded, shifted and saturated
// sum. Reset loads an identity response (c[0] = 1 << SHIFT).
module fir_filter import fir_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 4,
  parameter int CW    = 8,
  parameter int SHIFT = 2,
  parameter int ROUND = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      clear,
  input  logic                      coef_we,
  input  logic [clog2(TAPS)-1:0]    coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data
);

  localparam int ACCW = acc_width(WIDTH, CW, TAPS);
  localparam int PW   = WIDTH + CW;

  logic [CW-1:0]              r_coef [TAPS];
  logic [PW-1:0]              r_prod [TAPS];
  logic                       r_v1;
  logic [(TAPS-1)*WIDTH-1:0]  w_hist;
  logic [WIDTH-1:0]           w_x [TAPS];
  logic [ACCW-1:0]            w_sum;
  logic [WIDTH-1:0]           w_y;

  fir_delay_line #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_delay (
    .CLK     (CLK),
    .RST     (RST),
    .i_valid (in_valid),
    .i_clear (clear),
    .i_data  (in_data),
    .o_hist  (w_hist)
  );

  // Tap operands: current sample plus history, with history forced to zero on clear.
  always_comb begin
    for (int k = 0; k < TAPS; k++) w_x[k] = '0;
    w_x[0] = in_data;
    for (int k = 1; k < TAPS; k++) begin
      w_x[k] = clear ? '0 : w_hist[(k-1)*WIDTH +: WIDTH];
    end
  end

  // Coefficient register file; out-of-range addresses match no entry and are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= CW'(reset_coef(k, SHIFT));
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++) begin
        if (int'(coef_addr) == k) r_coef[k] <= coef_data;
      end
    end
  end

  // Stage 1: products use the coefficients as they stood before any same-cycle write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1 <= 1'b0;
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < TAPS; k++) r_prod[k] <= PW'(w_x[k]) * PW'(r_coef[k]);
      end
    end
  end

  // Sum of products, then round, shift and clamp.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) w_sum = w_sum + ACCW'(r_prod[k]);
    w_y = WIDTH'(round_sat(64'(w_sum), WIDTH, SHIFT, ROUND != 0));
  end

  // Stage 2: result register; out_data only moves when a result is valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) out_data <= w_y;
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: hand-computed results are queued by the
// stimulus and matched against the output stream every cycle.
module tb_fir_filter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       clear = 1'b0;
  logic       coef_we = 1'b0;
  logic [1:0] coef_addr = 2'd0;
  logic [7:0] coef_data = 8'd0;
  logic       out_valid;
  logic [7:0] out_data;

  logic       v3 = 1'b0;
  logic [7:0] d3 = 8'd0;
  logic       we3 = 1'b0;
  logic [1:0] a3 = 2'd0;
  logic [7:0] cd3 = 8'd0;
  logic       ov3;
  logic [7:0] od3;

  int n_checks = 0;
  int n_errors = 0;
  int exp_mem [64];
  int wr_idx = 0;
  int rd_idx = 0;
  int last_exp = 0;
  logic ev1 = 1'b0;
  logic ev2 = 1'b0;
  logic rst_q = 1'b1;
  bit mon_en = 1'b0;

  always #5 CLK = ~CLK;

  fir_filter #(.WIDTH(8), .TAPS(4), .CW(8), .SHIFT(2), .ROUND(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Three-tap instance so that an address equal to TAPS is representable.
  fir_filter #(.WIDTH(8), .TAPS(3), .CW(8), .SHIFT(2), .ROUND(1)) dut3 (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (v3),
    .in_data   (d3),
    .clear     (1'b0),
    .coef_we   (we3),
    .coef_addr (a3),
    .coef_data (cd3),
    .out_valid (ov3),
    .out_data  (od3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] d, input int exp);
    in_valid = 1'b1;
    in_data  = d;
    exp_mem[wr_idx % 64] = exp;
    wr_idx++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [7:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic set_smoother();
    wr_coef(2'd0, 8'd1);
    wr_coef(2'd1, 8'd2);
    wr_coef(2'd2, 8'd1);
  endtask

  // Reference valid pipeline: two cycles of delay, flushed by reset.
  always @(posedge CLK) begin
    rst_q <= RST;
    if (RST) begin
      ev1 <= 1'b0;
      ev2 <= 1'b0;
    end else begin
      ev1 <= in_valid;
      ev2 <= ev1;
    end
  end

  // Output monitor: checks every cycle for valid timing, data, and hold behaviour.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (rst_q) last_exp = 0;
      if (ev2) begin
        check("out_valid", out_valid, 1);
        check("out_data", out_data, exp_mem[rd_idx % 64]);
        last_exp = exp_mem[rd_idx % 64];
        rd_idx++;
      end else begin
        check("idle_valid", out_valid, 0);
        check("hold_data", out_data, last_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    mon_en = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst3_valid", ov3, 0);

    // identity after reset
    idle(1);
    send(8'd200, 200);
    idle(3);

    // address equal to TAPS on the three-tap instance is ignored
    we3 = 1'b1; a3 = 2'd3; cd3 = 8'd0;
    tick();
    we3 = 1'b0;
    v3 = 1'b1; d3 = 8'd9;
    tick();
    v3 = 1'b0;
    tick();
    check("oob_valid", ov3, 1);
    check("oob_data", od3, 9);
    tick();
    check("oob_idle", ov3, 0);

    // legacy smoother, back-to-back
    do_reset();
    set_smoother();
    send(8'd4, 1);
    send(8'd8, 4);
    send(8'd12, 8);
    idle(3);

    // gapped input
    do_reset();
    set_smoother();
    send(8'd4, 1);
    idle(3);
    send(8'd8, 4);
    idle(1);
    send(8'd12, 8);
    idle(3);

    // saturation
    do_reset();
    for (int k = 0; k < 4; k++) wr_coef(2'(k), 8'd255);
    for (int k = 0; k < 4; k++) send(8'd255, 255);
    idle(3);

    // coefficient write racing a sample: old coefficient applies
    do_reset();
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd8;
    send(8'd10, 10);
    coef_we = 1'b0;
    send(8'd10, 20);
    idle(3);

    // clear racing a sample with non-zero history
    do_reset();
    set_smoother();
    send(8'd4, 1);
    send(8'd8, 4);
    clear = 1'b1;
    send(8'd12, 3);
    clear = 1'b0;
    send(8'd4, 7);
    idle(3);

    // reset mid-burst: nothing from the burst emerges, identity restored
    do_reset();
    set_smoother();
    in_valid = 1'b1; in_data = 8'd20;
    tick();
    RST = 1'b1; in_data = 8'd30;
    tick();
    in_data = 8'd40;
    tick();
    in_data = 8'd50;
    tick();
    in_valid = 1'b0;
    RST = 1'b0;
    idle(2);
    send(8'd7, 7);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
